// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, next-PC select, stall, boot bubble and flush pulse.
// Optional return-address stack enabled by defining PC_SEQ_RAS_EN.
module pc_sequencer #(
  parameter int unsigned     PC_W      = 32,
  parameter int unsigned     INC       = 4,
  parameter int unsigned     IMM_SHIFT = 2,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch,
  input  logic            zero,
  input  logic [15:0]     branch_imm,
  input  logic            jump,
  input  logic [25:0]     jump_target,
  input  logic            jr,
  input  logic [PC_W-1:0] jr_addr,
  input  logic            call,
  input  logic            ret,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus,
  output logic            valid,
  output logic            flush,
  output logic            ras_miss
);

  localparam logic [1:0] StBoot = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  localparam int unsigned JW = 26 + IMM_SHIFT;

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            flush_q, flush_d;
  logic            ras_miss_q, ras_miss_d;

  logic            advance;
  logic            taken;
  logic            redirect;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] branch_pc;
  logic [JW-1:0]   jt_full;
  logic [PC_W-1:0] jump_pc;
  logic [PC_W-1:0] jr_target;
  logic            pop_miss;
  logic [PC_W-1:0] next_pc;

  assign pc_plus   = pc_q + PC_W'(INC);
  assign advance   = ((state_q == StRun) || (state_q == StHold)) && !stall;
  assign taken     = branch & zero;
  assign redirect  = jr | jump | taken;
  assign br_off    = PC_W'($signed(branch_imm)) << IMM_SHIFT;
  assign branch_pc = pc_plus + br_off;
  assign jt_full   = JW'(jump_target) << IMM_SHIFT;

  // Upper PC bits come from pc_plus only when the PC is wider than the jump field.
  if (PC_W > JW) begin : g_jump_wide
    assign jump_pc = {pc_plus[PC_W-1:JW], jt_full};
  end else begin : g_jump_narrow
    assign jump_pc = jt_full[PC_W-1:0];
  end

`ifdef PC_SEQ_RAS_EN
  localparam int unsigned   SPW     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW:0]   CNT_ONE = (SPW + 1)'(1);
  localparam logic [SPW:0]   CNT_MAX = (SPW + 1)'(RAS_DEPTH);

  logic [PC_W-1:0] ras_q [RAS_DEPTH];
  logic [SPW-1:0]  sp_q;
  logic [SPW:0]    cnt_q;
  logic [SPW-1:0]  top_idx;
  logic            ras_empty;
  logic            push;
  logic            pop;
  logic            pop_hit;

  assign top_idx   = sp_q - SP_ONE;
  assign ras_empty = (cnt_q == '0);
  assign push      = advance & jump & call;
  assign pop       = advance & jr & ret;
  assign pop_hit   = pop & !ras_empty;
  assign pop_miss  = pop & ras_empty;
  assign jr_target = pop_hit ? ras_q[top_idx] : jr_addr;

  // sp_q points at the next free slot; when full that slot holds the oldest entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else if (pop_hit && push) begin
      ras_q[top_idx] <= pc_plus;
    end else if (pop_hit) begin
      sp_q  <= top_idx;
      cnt_q <= cnt_q - CNT_ONE;
    end else if (push) begin
      ras_q[sp_q] <= pc_plus;
      sp_q        <= sp_q + SP_ONE;
      if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_ONE;
    end
  end
`else
  logic unused_ras;
  assign unused_ras = call ^ ret ^ (RAS_DEPTH == 0);
  assign pop_miss   = 1'b0;
  assign jr_target  = jr_addr;
`endif

  always_comb begin
    next_pc = pc_plus;
    if (jr)         next_pc = jr_target;
    else if (jump)  next_pc = jump_pc;
    else if (taken) next_pc = branch_pc;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    flush_d    = 1'b0;
    ras_miss_d = 1'b0;
    if (state_q == StBoot) begin
      state_d = StRun;
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b1;
      if (stall) begin
        state_d = StHold;
      end else begin
        state_d    = StRun;
        pc_d       = next_pc;
        flush_d    = redirect;
        ras_miss_d = pop_miss;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_VEC;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      ras_miss_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
      ras_miss_q <= ras_miss_d;
    end
  end

  assign pc       = pc_q;
  assign valid    = valid_q;
  assign flush    = flush_q;
  assign ras_miss = ras_miss_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 32-bit byte-addressed instance and an 8-bit word-indexed one.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, branch, zero, jump, jr, call, ret;
  logic [15:0] branch_imm;
  logic [25:0] jump_target;
  logic [31:0] jr_addr, pc, pc_plus;
  logic        valid, flush, ras_miss;

  logic        jr8;
  logic [7:0]  jr_addr8, pc8, pc_plus8;
  logic        valid8, flush8, ras_miss8;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .zero(zero),
    .branch_imm(branch_imm), .jump(jump), .jump_target(jump_target), .jr(jr),
    .jr_addr(jr_addr), .call(call), .ret(ret), .pc(pc), .pc_plus(pc_plus),
    .valid(valid), .flush(flush), .ras_miss(ras_miss)
  );

  pc_sequencer #(.PC_W(8), .INC(1)) dut8 (
    .clk(clk), .rst(rst), .stall(1'b0), .branch(1'b0), .zero(1'b0),
    .branch_imm(16'h0), .jump(1'b0), .jump_target(26'h0), .jr(jr8),
    .jr_addr(jr_addr8), .call(1'b0), .ret(1'b0), .pc(pc8), .pc_plus(pc_plus8),
    .valid(valid8), .flush(flush8), .ras_miss(ras_miss8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall = 0; branch = 0; zero = 0; branch_imm = 0; jump = 0; jump_target = 0;
    jr = 0; jr_addr = 0; call = 0; ret = 0;
  endtask

  task automatic go_jr(input logic [31:0] a);
    idle();
    jr = 1; jr_addr = a;
    step();
    check("jr_pc", pc, a);
    idle();
  endtask

  initial begin
    idle();
    jr8 = 0; jr_addr8 = 0;
    rst = 1;
    step();
    step();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_flush", {31'b0, flush}, 32'd0);
    check("rst_miss", {31'b0, ras_miss}, 32'd0);
    rst = 0;
    step();
    check("boot_pc", pc, 32'h0);
    check("boot_valid", {31'b0, valid}, 32'd1);
    step();
    check("seq_pc4", pc, 32'h4);
    check("seq_pc_plus", pc_plus, 32'h8);

    // Narrow instance: word-indexed PC wraps 0xFF -> 0x00.
    jr8 = 1; jr_addr8 = 8'hFF;
    step();
    check("n8_jr", {24'b0, pc8}, 32'hFF);
    check("seq_pc8", pc, 32'h8);
    jr8 = 0;
    step();
    check("n8_wrap", {24'b0, pc8}, 32'h00);
    check("seq_pc12", pc, 32'hC);

    branch = 1; zero = 1; branch_imm = 16'd3;
    step();
    check("br_taken_pc", pc, 32'd28);
    check("br_taken_flush", {31'b0, flush}, 32'd1);
    idle();
    step();
    check("after_br_pc", pc, 32'd32);
    check("flush_pulse", {31'b0, flush}, 32'd0);
    branch = 1; zero = 0; branch_imm = 16'd3;
    step();
    check("br_untaken_pc", pc, 32'd36);
    check("br_untaken_flush", {31'b0, flush}, 32'd0);
    branch = 1; zero = 1; branch_imm = 16'hFFFE;
    step();
    check("br_neg_pc", pc, 32'd32);

    go_jr(32'd16);
    stall = 1; jump = 1; jump_target = 26'h40;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc, 32'd16);
      check("stall_flush", {31'b0, flush}, 32'd0);
      check("stall_valid", {31'b0, valid}, 32'd1);
    end
    stall = 0;
    step();
    check("stall_release_pc", pc, 32'h100);
    check("stall_release_flush", {31'b0, flush}, 32'd1);

    go_jr(32'h7000_0000);
    jump = 1; jump_target = 26'h10;
    step();
    check("jump_upper_pc", pc, 32'h7000_0040);
    idle();

    jr = 1; jr_addr = 32'h100; jump = 1; jump_target = 26'h3FF;
    branch = 1; zero = 1; branch_imm = 16'd5;
    step();
    check("prio_jr", pc, 32'h100);
    idle();
    jump = 1; jump_target = 26'h200; branch = 1; zero = 1; branch_imm = 16'd5;
    step();
    check("prio_jump", pc, 32'h800);
    idle();

    go_jr(32'hFFFF_FFFC);
    check("wrap_pc_plus", pc_plus, 32'h0);
    step();
    check("wrap_pc", pc, 32'h0);

    stall = 1;
    step();
    rst = 1;
    step();
    check("rst_stall_pc", pc, 32'h0);
    check("rst_stall_valid", {31'b0, valid}, 32'd0);
    rst = 0; stall = 0;
    step();
    check("rst_stall_boot", {31'b0, valid}, 32'd1);
    check("rst_stall_boot_pc", pc, 32'h0);

`ifdef PC_SEQ_RAS_EN
    go_jr(32'h40);
    jump = 1; call = 1; jump_target = 26'h20;
    step();
    check("call1_pc", pc, 32'h80);
    jump_target = 26'h80;
    step();
    check("call2_pc", pc, 32'h200);
    idle();
    jr = 1; ret = 1; jr_addr = 32'h998;
    step();
    check("ret1_pc", pc, 32'h84);
    check("ret1_miss", {31'b0, ras_miss}, 32'd0);
    step();
    check("ret2_pc", pc, 32'h44);
    step();
    check("ret3_pc", pc, 32'h998);
    check("ret3_miss", {31'b0, ras_miss}, 32'd1);
    idle();
    step();
    check("miss_pulse", {31'b0, ras_miss}, 32'd0);

    // Five calls into a four-deep stack: the first return address is overwritten.
    for (int k = 1; k <= 5; k++) begin
      jump = 1; call = 1; jump_target = 26'(k * 32'h400);
      step();
      check("ovf_call_pc", pc, k * 32'h1000);
    end
    idle();
    for (int k = 4; k >= 1; k--) begin
      jr = 1; ret = 1; jr_addr = 32'hABC0;
      step();
      check("ovf_ret_pc", pc, k * 32'h1000 + 32'h4);
      check("ovf_ret_miss", {31'b0, ras_miss}, 32'd0);
    end
    step();
    check("ovf_lost_pc", pc, 32'hABC0);
    check("ovf_lost_miss", {31'b0, ras_miss}, 32'd1);
    idle();

    jump = 1; call = 1; jump_target = 26'h400;
    step();
    jump_target = 26'h800;
    step();
    idle();
    rst = 1;
    step();
    rst = 0;
    step();
    jr = 1; ret = 1; jr_addr = 32'h500;
    step();
    check("rst_ras_pc", pc, 32'h500);
    check("rst_ras_miss", {31'b0, ras_miss}, 32'd1);
    idle();
`else
    jump = 1; call = 1; jump_target = 26'h400;
    step();
    check("noras_call_pc", pc, 32'h1000);
    idle();
    jr = 1; ret = 1; jr_addr = 32'h500;
    step();
    check("noras_ret_pc", pc, 32'h500);
    check("noras_miss", {31'b0, ras_miss}, 32'd0);
    idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
